// File: rtl/aes_bist_ctrl.sv
// rtl/aes_bist_ctrl.sv - BIST engine for the 8-bit AES core: LFSR patterns, MISR compaction, golden compare
module aes_bist_ctrl #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS    = 8'b0110_0011,
  parameter logic [WIDTH-1:0] MISR_TAPS    = 8'b0110_0011,
  parameter logic [WIDTH-1:0] KEY_SEED     = 8'hA5,
  parameter logic [WIDTH-1:0] DATA_SEED    = 8'h0F,
  parameter int               NUM_PATTERNS = 256,
  parameter int               DUT_LATENCY  = 10,
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = 8'hC0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] data_in,
  output logic             pattern_valid,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  // A zero-latency build has no DRAIN phase; keep a 1-bit counter so the width stays legal.
  localparam int DW = (DUT_LATENCY > 0) ? $clog2(DUT_LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(NUM_PATTERNS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     pat_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [WIDTH-1:0]  key_q;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  sig_q;
  logic              done_q;
  logic              pass_q;
  logic              load;
  logic              last_pat;
  logic              misr_en;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], ^(q & MISR_TAPS)};
  endfunction

  assign last_pat = pattern_valid && (pat_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start is only honoured from IDLE or DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (last_pat) state_nxt = (DUT_LATENCY == 0) ? S_COMPARE : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    pattern_valid = 1'b0;
    busy          = 1'b0;
    load          = 1'b0;
    case (state)
      S_RUN:          begin pattern_valid = 1'b1; busy = 1'b1; end
      S_DRAIN:        busy = 1'b1;
      S_COMPARE:      busy = 1'b1;
      S_IDLE, S_DONE: load = start;
      default:        ;
    endcase
  end

  // Pattern generators: reload on start, step while presenting, hold on the last pattern
  always_ff @(posedge clk) begin
    if (rst || load) begin
      key_q  <= KEY_SEED;
      data_q <= DATA_SEED;
    end else if (pattern_valid && !last_pat) begin
      key_q  <= lfsr_step(key_q);
      data_q <= lfsr_step(data_q);
    end
  end

  // Pattern and drain counters, both wrapping back to zero at their last value
  always_ff @(posedge clk) begin
    if (rst || load) begin
      pat_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (pattern_valid) begin
        pat_cnt <= last_pat ? '0 : pat_cnt + 1'b1;
      end
      if (state == S_DRAIN) begin
        drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + 1'b1;
      end
    end
  end

  // Latency compensation: misr_en trails pattern_valid by the core's pipeline depth
  generate
    if (DUT_LATENCY == 0) begin : g_no_lat
      assign misr_en = pattern_valid;
    end else begin : g_lat
      localparam int LW = DUT_LATENCY;
      logic [LW-1:0] pipe;
      logic [LW-1:0] pv_ext;
      assign pv_ext  = LW'(pattern_valid);
      assign misr_en = pipe[LW-1];
      // Cleared shift pipe carrying pattern_valid toward the MISR
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe <= '0;
        end else begin
          pipe <= (pipe << 1) | pv_ext;
        end
      end
    end
  endgenerate

  // Signature register: cleared on start, compacts core output only inside the window
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig_q <= '0;
    end else if (misr_en) begin
      sig_q <= misr_step(sig_q) ^ data_out;
    end
  end

  // Result flags: set in COMPARE, held through DONE, dropped by the next start
  always_ff @(posedge clk) begin
    if (rst || load) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (state == S_COMPARE) begin
      done_q <= 1'b1;
      pass_q <= (sig_q == GOLDEN_SIG);
    end
  end

  assign key_in  = key_q;
  assign data_in = data_q;
  assign sig     = sig_q;
  assign done    = done_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// tb/tb_aes_bist_ctrl.sv - directed self-checking bench for aes_bist_ctrl
module tb_aes_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start0, start1, start2;
  logic [7:0] data_out0, data_out1, data_out2;
  logic [7:0] key0, key1, key2;
  logic [7:0] din0, din1, din2;
  logic       pv0, pv1, pv2;
  logic [7:0] sig0, sig1, sig2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;

  int tests = 0;
  int fails = 0;

  aes_bist_ctrl u0 (
    .clk(clk), .rst(rst), .start(start0), .data_out(data_out0),
    .key_in(key0), .data_in(din0), .pattern_valid(pv0), .sig(sig0),
    .busy(busy0), .done(done0), .pass(pass0)
  );

  aes_bist_ctrl #(.NUM_PATTERNS(4), .DUT_LATENCY(0), .GOLDEN_SIG(8'h00)) u1 (
    .clk(clk), .rst(rst), .start(start1), .data_out(data_out1),
    .key_in(key1), .data_in(din1), .pattern_valid(pv1), .sig(sig1),
    .busy(busy1), .done(done1), .pass(pass1)
  );

  aes_bist_ctrl #(.NUM_PATTERNS(16), .DUT_LATENCY(3), .GOLDEN_SIG(8'h00)) u2 (
    .clk(clk), .rst(rst), .start(start2), .data_out(data_out2),
    .key_in(key2), .data_in(din2), .pattern_valid(pv2), .sig(sig2),
    .busy(busy2), .done(done2), .pass(pass2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model for u2: output = key^data of the pattern 3 cycles earlier, FF when none
  logic [8:0] h1 = '0, h2 = '0, h3 = '0;
  initial begin
    data_out2 = 8'hFF;
    forever begin
      @(negedge clk);
      data_out2 = h3[8] ? h3[7:0] : 8'hFF;
      h3 = h2;
      h2 = h1;
      h1 = {pv2, key2 ^ din2};
    end
  end

  typedef struct {
    logic [7:0] key;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: done never seen within cycle budget", name);
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // n = 1 on the sample right after the start edge
  task automatic wait_done(input int sel, input int budget, output int n, output logic ok);
    n = 1;
    while (!done_of(sel) && n < budget) begin
      tick();
      n++;
    end
    ok = done_of(sel);
  endtask

  function automatic logic [7:0] step8(input logic [7:0] q);
    return {q[6:0], ^(q & 8'b0110_0011)};
  endfunction

  int         n;
  int         pv_cnt;
  logic       ok;
  logic [7:0] mk, md, ms;
  logic [7:0] run1_sig;
  logic       run1_pass;

  initial begin
    tbl[0] = '{8'hA5, 8'h0F};
    tbl[1] = '{8'h4A, 8'h1E};
    tbl[2] = '{8'h94, 8'h3D};
    tbl[3] = '{8'h28, 8'h7A};

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    data_out0 = 8'h00; data_out1 = 8'h00;
    tick();
    tick();
    check("rst_key", key0, 8'hA5);
    check("rst_data", din0, 8'h0F);
    check("rst_sig", sig0, 8'h00);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_pass", pass0, 1'b0);
    check("rst_pv", pv0, 1'b0);
    rst = 1'b0;

    // Default build: pattern sequence, run length, and a start mid-run that must be ignored
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 1; pv_cnt = 0; ok = 1'b0;
    while (n <= 2000) begin
      if (n <= 4) begin
        check($sformatf("seq_key_%0d", n - 1), key0, tbl[n-1].key);
        check($sformatf("seq_data_%0d", n - 1), din0, tbl[n-1].data);
      end
      pv_cnt += int'(pv0);
      if (done0) begin
        ok = 1'b1;
        break;
      end
      start0 = (n == 50);
      tick();
      n++;
    end
    start0 = 1'b0;
    if (!ok) timeout("u0_run");
    else begin
      check("u0_run_len", n, 268);
      check("u0_pv_cycles", pv_cnt, 256);
      check("u0_sig", sig0, 8'h00);
      check("u0_pass", pass0, 1'b0);
    end

    // Restart from DONE, then abort with rst at RUN cycle 100
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("u0_restart_done_drop", done0, 1'b0);
    check("u0_restart_busy", busy0, 1'b1);
    for (int i = 0; i < 100; i++) tick();
    check("u0_mid_busy", busy0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_key", key0, 8'hA5);
    check("abort_data", din0, 8'h0F);
    check("abort_sig", sig0, 8'h00);
    check("abort_busy", busy0, 1'b0);
    check("abort_done", done0, 1'b0);
    check("abort_pass", pass0, 1'b0);
    check("abort_pv", pv0, 1'b0);

    // Zero latency, 4 patterns, data_out tied 00
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done(1, 100, n, ok);
    if (!ok) timeout("u1_run_a");
    else begin
      check("u1_run_len", n, 6);
      check("u1_sig_zero", sig1, 8'h00);
      check("u1_pass_zero", pass1, 1'b1);
    end

    // Same, but 01 on the first misr_en cycle: sig 01 -> 03 -> 06 -> 0D
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("u1_first_pv", pv1, 1'b1);
    data_out1 = 8'h01;
    tick();
    data_out1 = 8'h00;
    wait_done(1, 100, n, ok);
    if (!ok) timeout("u1_run_b");
    else begin
      check("u1_run_len_b", n, 5);
      check("u1_sig_hit", sig1, 8'h0D);
      check("u1_pass_hit", pass1, 1'b0);
    end

    // Latency-3 alignment against a reference MISR over key^data
    mk = 8'hA5; md = 8'h0F; ms = 8'h00;
    for (int k = 0; k < 16; k++) begin
      ms = step8(ms) ^ (mk ^ md);
      mk = step8(mk);
      md = step8(md);
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_done(2, 200, n, ok);
    if (!ok) timeout("u2_run_a");
    else begin
      check("u2_run_len", n, 21);
      check("u2_sig", sig2, ms);
      check("u2_pass", pass2, ms == 8'h00);
    end
    run1_sig  = sig2;
    run1_pass = pass2;
    for (int i = 0; i < 4; i++) tick();
    check("u2_sig_hold_ff", sig2, ms);

    // Rerun from DONE reproduces the same result
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("u2_rerun_done_drop", done2, 1'b0);
    wait_done(2, 200, n, ok);
    if (!ok) timeout("u2_run_b");
    else begin
      check("u2_rerun_len", n, 21);
      check("u2_rerun_sig", sig2, run1_sig);
      check("u2_rerun_pass", pass2, run1_pass);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
